// File: rtl/mine_pkg.sv
// Shared constants and types for the mine placement datapath.
package mine_pkg;
  localparam int unsigned CELLS_DEF = 9;
  localparam int unsigned IDX_W     = $clog2(CELLS_DEF);

  localparam int unsigned       LFSR_W    = 8;
  // Taps for x^8+x^6+x^5+x^4+1 on a left-shifting Fibonacci register.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    IDLE,
    PLACE,
    DONE
  } state_t;
endpackage

// File: rtl/mine_placer_if.sv
// Handshake between the mine placer and the datapath register stage.
interface mine_placer_if #(
  parameter int unsigned CELLS = mine_pkg::CELLS_DEF
);
  logic             start;
  logic [CELLS-1:0] mines;
  logic             place_done;
  logic             busy;

  modport master (output start, input mines, input place_done, input busy);
  modport slave  (input start, output mines, output place_done, output busy);
endinterface

// File: rtl/mine_placer_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR; an all-zero seed is replaced by 8'h01.
module lfsr8
  import mine_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [LFSR_W-1:0] state
);
  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;

  logic fb;
  assign fb = ^(state & LFSR_TAPS);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SEED_EFF;
    else        state <= {state[LFSR_W-2:0], fb};
  end
endmodule

// File: rtl/mine_placer.sv
// Places NUM_MINES distinct mines on a CELLS-cell board by LFSR rejection sampling.
// Optional safe-cell exclusion is built when MINE_PLACER_SAFE_CELL_EN is defined.
module mine_placer
  import mine_pkg::*;
#(
  parameter int unsigned       CELLS     = CELLS_DEF,
  parameter int unsigned       NUM_MINES = 3,
  parameter logic [LFSR_W-1:0] SEED      = 8'hA5
) (
  input logic clka,
  input logic restart_n,
`ifdef MINE_PLACER_SAFE_CELL_EN
  input logic [((CELLS > 1) ? $clog2(CELLS) : 1)-1:0] safe_cell,
`endif
  mine_placer_if.slave bus
);
  localparam int unsigned CAND_W = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int unsigned PAD_W  = 1 << CAND_W;
  localparam int unsigned CNT_W  = $clog2(CELLS + 1);
`ifdef MINE_PLACER_SAFE_CELL_EN
  localparam int unsigned MAX_MINES = CELLS - 1;
`else
  localparam int unsigned MAX_MINES = CELLS;
`endif

  if (NUM_MINES < 1 || NUM_MINES > MAX_MINES) begin : g_bad_num_mines
    $error("mine_placer: NUM_MINES out of range");
  end

  logic [LFSR_W-1:0] lfsr;
  lfsr8 #(.SEED(SEED)) u_lfsr (.clk(clka), .rst_n(restart_n), .state(lfsr));

  logic [CAND_W-1:0] cand;
  logic              unused_lfsr_hi;
  assign cand           = lfsr[CAND_W-1:0];
  assign unused_lfsr_hi = ^lfsr[LFSR_W-1:CAND_W];

  // Padding the map to a power of two keeps the occupancy lookup in range for any candidate.
  logic [PAD_W-1:0] mines_pad;
  logic [CELLS-1:0] onehot;
  assign mines_pad = PAD_W'(bus.mines);
  assign onehot    = CELLS'(1) << cand;

  logic is_safe;
`ifdef MINE_PLACER_SAFE_CELL_EN
  logic [CAND_W-1:0] safe_q;
  // An out-of-range safe cell never matches, since such candidates are already rejected.
  assign is_safe = (cand == safe_q);
`else
  assign is_safe = 1'b0;
`endif

  state_t          state;
  logic [CNT_W-1:0] count;
  logic            accept;
  logic            last;
  assign accept = (32'(cand) < CELLS) && !mines_pad[cand] && !is_safe;
  assign last   = (count == CNT_W'(NUM_MINES - 1));

  // NOTE: the map is reset so a placement interrupted by restart_n never leaks a partial board.
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      state          <= IDLE;
      count          <= '0;
      bus.mines      <= '0;
      bus.place_done <= 1'b0;
      bus.busy       <= 1'b0;
`ifdef MINE_PLACER_SAFE_CELL_EN
      safe_q         <= '1;
`endif
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          bus.mines      <= '0;
          count          <= '0;
          bus.busy       <= 1'b1;
          bus.place_done <= 1'b0;
          state          <= PLACE;
`ifdef MINE_PLACER_SAFE_CELL_EN
          safe_q         <= safe_cell;
`endif
        end
        PLACE: if (accept) begin
          bus.mines <= bus.mines | onehot;
          count     <= count + 1'b1;
          if (last) begin
            bus.busy       <= 1'b0;
            bus.place_done <= 1'b1;
            state          <= DONE;
          end
        end
        DONE: if (!bus.start) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mine_placer.sv
// Self-checking bench for mine_placer against a sequence-level placement model.
module tb_mine_placer;
  localparam int CELLS = 9;
`ifdef MINE_PLACER_SAFE_CELL_EN
  localparam int FULL_N = 8;
`else
  localparam int FULL_N = 9;
`endif

  logic clka = 1'b0;
  logic restart_n = 1'b0;
  always #5 clka = ~clka;

`ifdef MINE_PLACER_SAFE_CELL_EN
  logic [3:0] safe_cell = 4'd15;
`endif

  mine_placer_if #(.CELLS(CELLS)) if_main ();
  mine_placer_if #(.CELLS(CELLS)) if_full ();
  mine_placer_if #(.CELLS(CELLS)) if_s0 ();

  mine_placer #(.CELLS(CELLS), .NUM_MINES(3), .SEED(8'hA5)) dut (
    .clka(clka), .restart_n(restart_n),
`ifdef MINE_PLACER_SAFE_CELL_EN
    .safe_cell(safe_cell),
`endif
    .bus(if_main)
  );

  mine_placer #(.CELLS(CELLS), .NUM_MINES(FULL_N), .SEED(8'hA5)) dut_full (
    .clka(clka), .restart_n(restart_n),
`ifdef MINE_PLACER_SAFE_CELL_EN
    .safe_cell(safe_cell),
`endif
    .bus(if_full)
  );

  mine_placer #(.CELLS(CELLS), .NUM_MINES(3), .SEED(8'h00)) dut_s0 (
    .clka(clka), .restart_n(restart_n),
`ifdef MINE_PLACER_SAFE_CELL_EN
    .safe_cell(safe_cell),
`endif
    .bus(if_s0)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Next state of x^8+x^6+x^5+x^4+1: shift up, feed back the parity of the tapped bits.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    int par;
    par = $countones(s & 8'hB8) % 2;
    return {s[6:0], 1'b0} | 8'(par);
  endfunction

  // Walk the candidate sequence, keeping the first nm distinct eligible cells.
  function automatic void predict(input logic [7:0] s_in, input int nm, input int safe,
                                  output logic [8:0] map, output int cyc);
    logic [7:0] s;
    int placed;
    int c;
    s = s_in; placed = 0; map = '0; cyc = 0;
    while (placed < nm && cyc < 4096) begin
      c = int'(s) % 16;
      cyc++;
      if (c < CELLS && !map[c] && c != safe) begin
        map[c] = 1'b1;
        placed++;
      end
      s = lfsr_next(s);
    end
  endfunction

  function automatic int safe_model();
`ifdef MINE_PLACER_SAFE_CELL_EN
    return int'(safe_cell);
`else
    return -1;
`endif
  endfunction

  logic [7:0] ref_a5, ref_01;
  always @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      ref_a5 <= 8'hA5;
      ref_01 <= 8'h01;
    end else begin
      ref_a5 <= lfsr_next(ref_a5);
      ref_01 <= lfsr_next(ref_01);
    end
  end

  int s0_zero = 0;
  always @(posedge clka) if (restart_n && dut_s0.lfsr == 8'h00) s0_zero++;

  task automatic place_main(output logic [8:0] got, output int cyc);
    logic [8:0] exp_map;
    int exp_cyc;
    int k;
    @(negedge clka);
    if_main.start = 1'b1;
    @(posedge clka); #1;
    check("busy_after_start", if_main.busy, 1);
    check("done_clear_after_start", if_main.place_done, 0);
    predict(ref_a5, 3, safe_model(), exp_map, exp_cyc);
    k = 0;
    while (!if_main.place_done && k < 765) begin
      @(posedge clka); #1;
      k++;
    end
    check("place_done_reached", if_main.place_done, 1);
    check("place_latency", k, exp_cyc);
    check("mines_map", if_main.mines, exp_map);
    check("mines_popcount", $countones(if_main.mines), 3);
    check("busy_clear_at_done", if_main.busy, 0);
    got = if_main.mines;
    cyc = k;
  endtask

  task automatic drop_start();
    @(negedge clka);
    if_main.start = 1'b0;
    @(posedge clka); #1;
  endtask

  initial begin
    logic [8:0] first_map, m, exp_full, exp_s0;
    int first_cyc, c, k, kf, ks, cyc_full, cyc_s0;
    logic held_ok, saw2;

    if_main.start = 1'b0;
    if_full.start = 1'b0;
    if_s0.start   = 1'b0;
    #22;
    check("reset_mines", if_main.mines, 0);
    check("reset_place_done", if_main.place_done, 0);
    check("reset_busy", if_main.busy, 0);
    check("reset_lfsr", dut.lfsr, 8'hA5);
    check("reset_lfsr_seed0", dut_s0.lfsr, 8'h01);
    @(negedge clka);
    restart_n = 1'b1;

    place_main(first_map, first_cyc);
    check("lfsr_tracks_model", dut.lfsr, ref_a5);

    held_ok = 1'b1;
    repeat (50) begin
      @(posedge clka); #1;
      if (if_main.mines !== first_map || if_main.place_done !== 1'b1 || if_main.busy !== 1'b0)
        held_ok = 1'b0;
    end
    check("hold_start_stable", held_ok, 1);

    drop_start();
    check("idle_keeps_done", if_main.place_done, 1);
    check("idle_keeps_mines", if_main.mines, first_map);

    place_main(m, c);
    drop_start();

    // Interrupt a placement right after its first accepted mine.
    @(negedge clka);
    if_main.start = 1'b1;
    @(posedge clka); #1;
    k = 0;
    while (dut.count != 1 && k < 255) begin
      @(posedge clka); #1;
      k++;
    end
    check("count_reached_one", dut.count, 1);
    restart_n = 1'b0;
    if_main.start = 1'b0;
    #1;
    check("async_reset_mines", if_main.mines, 0);
    check("async_reset_done", if_main.place_done, 0);
    check("async_reset_busy", if_main.busy, 0);
    check("async_reset_lfsr", dut.lfsr, 8'hA5);
    restart_n = 1'b1;
    @(posedge clka);
    place_main(m, c);
    check("replay_map", m, first_map);
    check("replay_latency", c, first_cyc);
    drop_start();

    // Full board and zero-seed variants run side by side.
    @(negedge clka);
    if_full.start = 1'b1;
    if_s0.start   = 1'b1;
    @(posedge clka); #1;
    predict(ref_a5, FULL_N, safe_model(), exp_full, cyc_full);
    predict(ref_01, 3, safe_model(), exp_s0, cyc_s0);
    k = 0; kf = -1; ks = -1;
    while ((kf < 0 || ks < 0) && k < 2295) begin
      @(posedge clka); #1;
      k++;
      if (kf < 0 && if_full.place_done) kf = k;
      if (ks < 0 && if_s0.place_done) ks = k;
    end
    check("full_latency", kf, cyc_full);
    check("full_map", if_full.mines, exp_full);
    check("full_popcount", $countones(if_full.mines), FULL_N);
`ifndef MINE_PLACER_SAFE_CELL_EN
    check("full_all_ones", if_full.mines, 9'h1FF);
`endif
    check("seed0_latency", ks, cyc_s0);
    check("seed0_map", if_s0.mines, exp_s0);
    @(negedge clka);
    if_full.start = 1'b0;
    if_s0.start   = 1'b0;

    saw2 = 1'b0;
    for (int r = 0; r < 300; r++) begin
`ifdef MINE_PLACER_SAFE_CELL_EN
      safe_cell = (r < 200) ? 4'd2 : 4'd12;
`endif
      repeat ($urandom_range(0, 20)) @(posedge clka);
      place_main(m, c);
`ifdef MINE_PLACER_SAFE_CELL_EN
      if (r < 200) check("safe_cell_clear", m[2], 0);
`endif
      if (r >= 200) saw2 = saw2 | m[2];
      drop_start();
    end
    check("cell2_reachable", saw2, 1);
    check("seed0_never_zero", s0_zero, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
